// File: rtl/div_pkg.sv
// Shared constants and FSM state type for the 8-bit restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 8;
  localparam int CNT_WIDTH = 3;
  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/divider_8bit_if.sv
// Start/done handshake and operand/result bundle between a requester and the divider.
interface divider_8bit_if #(
  parameter int WIDTH = div_pkg::DIV_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/trial_subtractor.sv
// Combinational 9-bit minus 8-bit trial subtraction built from chained full-subtract cells.
module trial_subtractor
  import div_pkg::*;
(
  input  logic [DIV_WIDTH:0]   minuend,
  input  logic [DIV_WIDTH-1:0] subtrahend,
  output logic [DIV_WIDTH:0]   diff,
  output logic                 borrow
);

  logic [DIV_WIDTH:0]   sub_ext;
  logic [DIV_WIDTH+1:0] chain;

  assign sub_ext  = {1'b0, subtrahend};
  assign chain[0] = 1'b0;

  for (genvar i = 0; i <= DIV_WIDTH; i++) begin : g_cell
    assign diff[i]    = minuend[i] ^ sub_ext[i] ^ chain[i];
    assign chain[i+1] = (~minuend[i] & sub_ext[i]) |
                        (~(minuend[i] ^ sub_ext[i]) & chain[i]);
  end

  assign borrow = chain[DIV_WIDTH+1];

endmodule

// File: rtl/divider_8bit.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake.
module divider_8bit
  import div_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  divider_8bit_if.slave  bus
);

  state_t                 state, next_state;
  logic [DIV_WIDTH-1:0]   q_reg;
  logic [DIV_WIDTH-1:0]   r_reg;
  logic [DIV_WIDTH-1:0]   d_reg;
  logic [CNT_WIDTH-1:0]   cnt;
  logic                   busy_reg;
  logic                   done_reg;
  logic                   dbz_reg;

  logic [DIV_WIDTH:0]     r_shift;
  logic [DIV_WIDTH:0]     diff;
  logic                   borrow;
  logic [DIV_WIDTH:0]     r_next;
  logic                   unused_r_msb;

  assign r_shift = {r_reg, q_reg[DIV_WIDTH-1]};

  trial_subtractor u_sub (
    .minuend    (r_shift),
    .subtrahend (d_reg),
    .diff       (diff),
    .borrow     (borrow)
  );

  assign r_next = borrow ? r_shift : diff;
  // A restored or accepted partial remainder is always below the divisor, so bit 8 is zero.
  assign unused_r_msb = r_next[DIV_WIDTH];

  // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = (bus.divisor == '0) ? DONE : RUN;
      RUN:     if (cnt == CNT_WIDTH'(DIV_WIDTH - 1)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: reset is synchronous; every register, including the datapath, clears on rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg    <= '0;
      r_reg    <= '0;
      d_reg    <= '0;
      cnt      <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      dbz_reg  <= 1'b0;
    end else begin
      busy_reg <= (next_state != IDLE);
      done_reg <= (next_state == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              q_reg   <= DIV0_QUOTIENT;
              r_reg   <= bus.dividend;
              dbz_reg <= 1'b1;
            end else begin
              q_reg   <= bus.dividend;
              r_reg   <= '0;
              d_reg   <= bus.divisor;
              cnt     <= '0;
              dbz_reg <= 1'b0;
            end
          end
        end
        RUN: begin
          q_reg <= {q_reg[DIV_WIDTH-2:0], ~borrow};
          r_reg <= r_next[DIV_WIDTH-1:0];
          cnt   <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.quotient    = q_reg;
  assign bus.remainder   = r_reg;
  assign bus.div_by_zero = dbz_reg;

endmodule
